pyrm_writeback_block: RTL and testbench

- Final pipeline stage; the producer side of the decode block's register-write port.
- Collects completed results from the ALU path and the memory (load) path.
- Formats load data by size and sign, and drops writes to x0.
- Queues writes in a small FIFO and presents one {reg_addr, reg_data} pair per cycle to decode, which uses it to update the register file, clear scoreboard bits and forward operands.

---
 rtl/pyrm_writeback_block_pkg.sv | 52 +++++
 rtl/pyrm_writeback_block_wb_fifo.sv | 71 +++++++
 rtl/pyrm_writeback_block.sv | 92 +++++++++
 tb/tb_pyrm_writeback_block.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyrm_writeback_block_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_entry_t  : one pending register write {rd, data}
//   LD_*        : load funct3 encodings
//   fmt_load()  : selects and extends the loaded field from an aligned doubleword
package pyrm_writeback_block_pkg;

    localparam int RD_W    = 5;
    localparam int DATA_W  = 64;
    localparam int ENTRY_W = RD_W + DATA_W;

    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_D  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;
    localparam logic [2:0] LD_WU = 3'd6;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Shift the addressed field down to bit 0, then extend. Sub-size offset
    // bits are ignored, so misaligned halfword/word offsets round down.
    // funct3=7 falls through to the doubleword case.
    function automatic logic [DATA_W-1:0] fmt_load(
        input logic [DATA_W-1:0] raw,
        input logic [2:0]        off,
        input logic [2:0]        f3
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        case (f3)
            LD_B, LD_BU: sh = raw >> {off, 3'b000};
            LD_H, LD_HU: sh = raw >> {off[2:1], 4'b0000};
            LD_W, LD_WU: sh = raw >> {off[2], 5'b00000};
            default:     sh = raw;
        endcase
        case (f3)
            LD_B:    res = {{56{sh[7]}},  sh[7:0]};
            LD_BU:   res = {56'd0,        sh[7:0]};
            LD_H:    res = {{48{sh[15]}}, sh[15:0]};
            LD_HU:   res = {48'd0,        sh[15:0]};
            LD_W:    res = {{32{sh[31]}}, sh[31:0]};
            LD_WU:   res = {32'd0,        sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pyrm_writeback_block_wb_fifo.sv
// wb_fifo: parameterized synchronous FIFO for pending register writes.
// Ports:
//   clk, rst_b      : clock, synchronous active-low reset (pointers/count only)
//   push_i          : enqueue push_data_i (ignored when full)
//   push_data_i     : entry to enqueue
//   pop_i           : dequeue head (ignored when empty)
//   full_o, empty_o : status from registered count
//   head_o          : oldest entry, valid when !empty_o
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[head_q];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        if (do_push) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_b) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pyrm_writeback_block.sv
// pyrm_writeback_block: final pipeline stage. Accepts ALU and load results,
// formats load data, drops x0 writes and queues the rest for decode.
// Ports:
//   clk, reset_pyri                 : clock, synchronous active-low reset
//   alu_*                           : ALU result channel (valid/retry)
//   mem_*                           : load result channel (raw doubleword + offset/funct3)
//   reg_addr_* / reg_data_*         : paired write channels to decode; always pop together
module pyrm_writeback_block
    import pyrm_writeback_block_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clk,
    input  logic        reset_pyri,
    input  logic [4:0]  alu_rd_pyri,
    input  logic [63:0] alu_data_pyri,
    input  logic        alu_valid_pyri,
    output logic        alu_retry_pyro,
    input  logic [4:0]  mem_rd_pyri,
    input  logic [63:0] mem_data_pyri,
    input  logic [2:0]  mem_offset_pyri,
    input  logic [2:0]  mem_funct3_pyri,
    input  logic        mem_valid_pyri,
    output logic        mem_retry_pyro,
    output logic [63:0] reg_addr_pyro,
    output logic        reg_addr_valid_pyro,
    input  logic        reg_addr_retry_pyri,
    output logic [63:0] reg_data_pyro,
    output logic        reg_data_valid_pyro,
    input  logic        reg_data_retry_pyri
);

    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        mem_accept;
    logic        alu_accept;
    logic        out_valid;
    logic [63:0] mem_fmt;
    wb_entry_t   push_entry;
    wb_entry_t   head;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_b       (reset_pyri),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    // Memory has priority; a valid load blocks the ALU even when it is x0.
    // Holding reset low forces retry so nothing is accepted during reset.
    always_comb begin
        mem_retry_pyro = !reset_pyri || fifo_full;
        alu_retry_pyro = !reset_pyri || fifo_full || mem_valid_pyri;
        mem_accept     = mem_valid_pyri && !mem_retry_pyro;
        alu_accept     = alu_valid_pyri && !alu_retry_pyro;
    end

    always_comb begin
        mem_fmt = fmt_load(mem_data_pyri, mem_offset_pyri, mem_funct3_pyri);
        if (mem_accept) begin
            push_entry.rd   = mem_rd_pyri;
            push_entry.data = mem_fmt;
        end else begin
            push_entry.rd   = alu_rd_pyri;
            push_entry.data = alu_data_pyri;
        end
        // x0 results are consumed by the handshake but never queued.
        push = (mem_accept && (mem_rd_pyri != 5'd0))
            || (alu_accept && (alu_rd_pyri != 5'd0));
    end

    always_comb begin
        out_valid           = reset_pyri && !fifo_empty;
        pop                 = out_valid && !(reg_addr_retry_pyri || reg_data_retry_pyri);
        reg_addr_valid_pyro = out_valid;
        reg_data_valid_pyro = out_valid;
        reg_addr_pyro       = out_valid ? {59'd0, head.rd} : 64'd0;
        reg_data_pyro       = out_valid ? head.data        : 64'd0;
    end

endmodule

// File: tb/tb_pyrm_writeback_block.sv
module tb_pyrm_writeback_block;

    logic        clk = 1'b0;
    logic        reset_pyri;
    logic [4:0]  alu_rd_pyri;
    logic [63:0] alu_data_pyri;
    logic        alu_valid_pyri;
    logic        alu_retry_pyro;
    logic [4:0]  mem_rd_pyri;
    logic [63:0] mem_data_pyri;
    logic [2:0]  mem_offset_pyri;
    logic [2:0]  mem_funct3_pyri;
    logic        mem_valid_pyri;
    logic        mem_retry_pyro;
    logic [63:0] reg_addr_pyro;
    logic        reg_addr_valid_pyro;
    logic        reg_addr_retry_pyri;
    logic [63:0] reg_data_pyro;
    logic        reg_data_valid_pyro;
    logic        reg_data_retry_pyri;

    int n_checks = 0;
    int n_err    = 0;
    bit rand_bp  = 1'b0;
    logic [68:0] sb [$];

    always #5 clk = ~clk;

    pyrm_writeback_block #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk                 (clk),
        .reset_pyri          (reset_pyri),
        .alu_rd_pyri         (alu_rd_pyri),
        .alu_data_pyri       (alu_data_pyri),
        .alu_valid_pyri      (alu_valid_pyri),
        .alu_retry_pyro      (alu_retry_pyro),
        .mem_rd_pyri         (mem_rd_pyri),
        .mem_data_pyri       (mem_data_pyri),
        .mem_offset_pyri     (mem_offset_pyri),
        .mem_funct3_pyri     (mem_funct3_pyri),
        .mem_valid_pyri      (mem_valid_pyri),
        .mem_retry_pyro      (mem_retry_pyro),
        .reg_addr_pyro       (reg_addr_pyro),
        .reg_addr_valid_pyro (reg_addr_valid_pyro),
        .reg_addr_retry_pyri (reg_addr_retry_pyri),
        .reg_data_pyro       (reg_data_pyro),
        .reg_data_valid_pyro (reg_data_valid_pyro),
        .reg_data_retry_pyri (reg_data_retry_pyri)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Byte-gather reference for load results.
    function automatic logic [63:0] ld_model(input logic [63:0] d, input logic [2:0] off,
                                             input logic [2:0] f3);
        int nb;
        int base;
        logic [63:0] r;
        logic s;
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2, 3'd6: nb = 4;
            default:    nb = 8;
        endcase
        base = int'(off) - (int'(off) % nb);
        r = 64'd0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*(base+i) +: 8];
        s = (f3 < 3'd3) ? r[8*nb-1] : 1'b0;
        for (int i = nb; i < 8; i++) r[8*i +: 8] = {8{s}};
        return r;
    endfunction

    // Called just after a posedge. Holds the request until the handshake
    // completes, then records the expected write (x0 is never expected).
    task automatic send(input bit is_mem, input logic [4:0] rd, input logic [63:0] data,
                        input logic [2:0] off, input logic [2:0] f3, input logic [63:0] exp_data);
        bit done = 1'b0;
        if (is_mem) begin
            mem_rd_pyri = rd; mem_data_pyri = data; mem_offset_pyri = off;
            mem_funct3_pyri = f3; mem_valid_pyri = 1'b1;
        end else begin
            alu_rd_pyri = rd; alu_data_pyri = data; alu_valid_pyri = 1'b1;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!(is_mem ? mem_retry_pyro : alu_retry_pyro)) begin
                if (rd != 5'd0) sb.push_back({rd, exp_data});
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (rand_bp) begin
                reg_addr_retry_pyri = ($urandom_range(0, 3) == 0);
                reg_data_retry_pyri = ($urandom_range(0, 3) == 0);
            end
        end
        mem_valid_pyri = 1'b0;
        alu_valid_pyri = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !reg_addr_valid_pyro) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: every pop is compared against the scoreboard head.
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            chk("valid_pair", 64'(reg_data_valid_pyro), 64'(reg_addr_valid_pyro));
            if (reg_addr_valid_pyro && !reg_addr_retry_pyri && !reg_data_retry_pyri) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", reg_addr_pyro, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wb_rd", reg_addr_pyro, {59'd0, e[68:64]});
                    chk("wb_data", reg_data_pyro, e[63:0]);
                end
            end else if (!reg_addr_valid_pyro) begin
                chk("idle_addr", reg_addr_pyro, 64'd0);
                chk("idle_data", reg_data_pyro, 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [63:0] LDATA = 64'h8877_6655_4433_2211;

    initial begin
        reset_pyri = 1'b0;
        alu_rd_pyri = 5'd5; alu_data_pyri = 64'h1234; alu_valid_pyri = 1'b1;
        mem_rd_pyri = '0; mem_data_pyri = '0; mem_offset_pyri = '0;
        mem_funct3_pyri = '0; mem_valid_pyri = 1'b0;
        reg_addr_retry_pyri = 1'b0; reg_data_retry_pyri = 1'b0;

        // reset hold with a pending ALU request
        repeat (3) begin
            @(negedge clk);
            chk("rst_alu_retry", 64'(alu_retry_pyro), 64'd1);
            chk("rst_mem_retry", 64'(mem_retry_pyro), 64'd1);
            chk("rst_valid", 64'(reg_addr_valid_pyro), 64'd0);
            chk("rst_addr", reg_addr_pyro, 64'd0);
        end
        @(posedge clk); #1;
        reset_pyri = 1'b1;
        @(negedge clk);
        chk("rel_alu_retry", 64'(alu_retry_pyro), 64'd0);
        sb.push_back({5'd5, 64'h1234});
        @(posedge clk); #1;
        alu_valid_pyri = 1'b0;
        @(negedge clk);
        chk("lat_valid", 64'(reg_addr_valid_pyro), 64'd1);
        chk("lat_addr", reg_addr_pyro, 64'h5);
        wait_empty();

        // load formatting
        send(1'b1, 5'd8,  LDATA, 3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FF88);
        send(1'b1, 5'd9,  LDATA, 3'd7, 3'd4, 64'h88);
        send(1'b1, 5'd10, LDATA, 3'd4, 3'd2, 64'hFFFF_FFFF_8877_6655);
        send(1'b1, 5'd11, LDATA, 3'd6, 3'd5, 64'h8877);
        send(1'b1, 5'd12, LDATA, 3'd5, 3'd7, LDATA);
        wait_empty();
        for (int i = 0; i < 16; i++) begin
            logic [63:0] d;
            logic [2:0] o, f;
            d = {$urandom, $urandom};
            o = 3'($urandom_range(0, 7));
            f = 3'($urandom_range(0, 7));
            send(1'b1, 5'(i + 1), d, o, f, ld_model(d, o, f));
        end
        wait_empty();

        // arbitration: memory first, ALU the following cycle
        alu_rd_pyri = 5'd3; alu_data_pyri = 64'hAA; alu_valid_pyri = 1'b1;
        mem_rd_pyri = 5'd4; mem_data_pyri = 64'hBB; mem_offset_pyri = 3'd0;
        mem_funct3_pyri = 3'd3; mem_valid_pyri = 1'b1;
        @(negedge clk);
        chk("arb_mem_retry", 64'(mem_retry_pyro), 64'd0);
        chk("arb_alu_retry", 64'(alu_retry_pyro), 64'd1);
        sb.push_back({5'd4, 64'hBB});
        @(posedge clk); #1;
        mem_valid_pyri = 1'b0;
        @(negedge clk);
        chk("arb_alu_next", 64'(alu_retry_pyro), 64'd0);
        sb.push_back({5'd3, 64'hAA});
        @(posedge clk); #1;
        alu_valid_pyri = 1'b0;
        wait_empty();

        // full / backpressure
        reg_data_retry_pyri = 1'b1;
        for (int r = 1; r <= 4; r++) send(1'b0, 5'(r), 64'h100 + 64'(r), 3'd0, 3'd0, 64'h100 + 64'(r));
        alu_rd_pyri = 5'd5; alu_data_pyri = 64'h105; alu_valid_pyri = 1'b1;
        @(negedge clk);
        chk("full_alu_retry", 64'(alu_retry_pyro), 64'd1);
        chk("full_mem_retry", 64'(mem_retry_pyro), 64'd1);
        chk("full_head", reg_addr_pyro, 64'h1);
        @(posedge clk); #1;
        reg_data_retry_pyri = 1'b0;
        send(1'b0, 5'd5, 64'h105, 3'd0, 3'd0, 64'h105);
        wait_empty();

        // x0 drop
        send(1'b0, 5'd0, 64'hDEAD, 3'd0, 3'd0, 64'hDEAD);
        @(negedge clk);
        chk("x0_valid", 64'(reg_addr_valid_pyro), 64'd0);
        @(posedge clk); #1;
        send(1'b0, 5'd7, 64'h1, 3'd0, 3'd0, 64'h1);
        wait_empty();

        // reset mid-stream discards queued entries
        reg_data_retry_pyri = 1'b1;
        for (int r = 20; r < 23; r++) send(1'b0, 5'(r), 64'(r), 3'd0, 3'd0, 64'(r));
        @(negedge clk);
        chk("mid_pre_valid", 64'(reg_addr_valid_pyro), 64'd1);
        @(posedge clk); #1;
        reset_pyri = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(reg_data_valid_pyro), 64'd0);
        chk("mid_rst_retry", 64'(alu_retry_pyro), 64'd1);
        chk("mid_rst_data", reg_data_pyro, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset_pyri = 1'b1;
        reg_data_retry_pyri = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_empty", 64'(reg_addr_valid_pyro), 64'd0);
        end
        @(posedge clk); #1;

        // random mix under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit m;
            logic [4:0] rd;
            logic [63:0] d;
            logic [2:0] o, f;
            m  = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            d  = {$urandom, $urandom};
            o  = 3'($urandom_range(0, 7));
            f  = 3'($urandom_range(0, 7));
            send(m, rd, d, o, f, m ? ld_model(d, o, f) : d);
        end
        rand_bp = 1'b0;
        reg_addr_retry_pyri = 1'b0;
        reg_data_retry_pyri = 1'b0;
        wait_empty();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
